// File: rtl/ws2801_driver.sv
// WS2801 LED-chain transmitter: pixels in over valid/ready, MSB-first serial out on SDO/CKO, then latch gap.
// Optional: define WS2801_UNDERRUN_EN to replace a missing pixel with black and pulse `underrun`.
module ws2801_driver #(
    parameter int unsigned LEDS         = 5,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned LATCH_CYCLES = 26000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        SDO,
    output logic        CKO,
    output logic        busy,
    output logic        frame_done
`ifdef WS2801_UNDERRUN_EN
    ,
    output logic        underrun
`endif
);
    localparam int unsigned PIX_W = (LEDS > 1) ? $clog2(LEDS) : 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned LAT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(LEDS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t            state_q;
    // Holds only the bits not yet presented on SDO; bit 22 is the next one out.
    logic [22:0]       shift_q;
    logic [4:0]        bit_q;
    logic [PIX_W-1:0]  pix_q;
    logic [DIV_W-1:0]  div_q;
    logic [LAT_W-1:0]  lat_q;
    logic              sdo_q;
    logic              cko_q;
    logic              busy_q;
    logic              done_q;
`ifdef WS2801_UNDERRUN_EN
    logic              underrun_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            pix_q      <= '0;
            div_q      <= '0;
            lat_q      <= '0;
            sdo_q      <= 1'b0;
            cko_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef WS2801_UNDERRUN_EN
            underrun_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef WS2801_UNDERRUN_EN
            underrun_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    bit_q <= '0;
                    pix_q <= '0;
                    div_q <= '0;
                    lat_q <= '0;
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    cko_q <= 1'b0;
                    div_q <= '0;
                    if (pixel_valid) begin
                        shift_q <= pixel_data[22:0];
                        sdo_q   <= pixel_data[23];
                        state_q <= SHIFT_LO;
                    end
`ifdef WS2801_UNDERRUN_EN
                    else begin
                        shift_q    <= '0;
                        sdo_q      <= 1'b0;
                        underrun_q <= 1'b1;
                        state_q    <= SHIFT_LO;
                    end
`endif
                end
                SHIFT_LO: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        cko_q   <= 1'b1;
                        state_q <= SHIFT_HI;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        cko_q   <= 1'b0;
                        shift_q <= {shift_q[21:0], 1'b0};
                        if (bit_q == 5'd23) begin
                            bit_q <= '0;
                            if (pix_q < PIX_LAST) begin
                                pix_q   <= pix_q + 1'b1;
                                state_q <= LOAD;
                            end else begin
                                sdo_q   <= 1'b0;
                                lat_q   <= '0;
                                state_q <= LATCH;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            sdo_q   <= shift_q[22];
                            state_q <= SHIFT_LO;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                LATCH: begin
                    if (lat_q == LAT_LAST) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pixel_ready = (state_q == LOAD);
    assign SDO         = sdo_q;
    assign CKO         = cko_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
`ifdef WS2801_UNDERRUN_EN
    assign underrun    = underrun_q;
`endif

endmodule

// File: tb/tb_ws2801_driver.sv
// Bench for ws2801_driver: random pixel frames checked against an expected serial bit queue.
`timescale 1ns/1ps
module tb_ws2801_driver;
    localparam int unsigned LEDS         = 2;
    localparam int unsigned CLK_DIV      = 2;
    localparam int unsigned LATCH_CYCLES = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        SDO;
    logic        CKO;
    logic        busy;
    logic        frame_done;
`ifdef WS2801_UNDERRUN_EN
    logic        underrun;
`endif

    always #5 clk = ~clk;

    ws2801_driver #(
        .LEDS(LEDS),
        .CLK_DIV(CLK_DIV),
        .LATCH_CYCLES(LATCH_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .SDO(SDO),
        .CKO(CKO),
        .busy(busy),
        .frame_done(frame_done)
`ifdef WS2801_UNDERRUN_EN
        ,
        .underrun(underrun)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected serial stream: each pixel contributes its 24 bits MSB first.
    bit exp_q[$];

    task automatic push_pixel(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) exp_q.push_back(p[i]);
    endtask

    int unsigned cyc = 0, t_rise = 0, t_fall = 0, rises_frame = 0;
    int unsigned done_cnt = 0, urun_cnt = 0;
    logic        prev_cko = 1'b0;
    logic        sdo_rise = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            rises_frame = 0;
        end else begin
            if (!prev_cko && CKO) begin
                if (rises_frame % 24 != 0) check_eq("cko_low_width", cyc - t_fall, CLK_DIV);
                rises_frame++;
                t_rise   = cyc;
                sdo_rise = SDO;
                if (exp_q.size() == 0) check_eq("extra_cko_rise", rises_frame, 0);
                else check_eq("sdo_bit", SDO, exp_q.pop_front());
            end else if (prev_cko && CKO) begin
                check_eq("sdo_stable_hi", SDO, sdo_rise);
            end else if (prev_cko && !CKO) begin
                check_eq("cko_high_width", cyc - t_rise, CLK_DIV);
                t_fall = cyc;
            end
            if (frame_done) begin
                check_eq("latch_gap", cyc - t_fall, LATCH_CYCLES);
                check_eq("rises_per_frame", rises_frame, 24 * LEDS);
                check_eq("frame_bits_left", exp_q.size(), 0);
                check_eq("busy_at_done", busy, 0);
                check_eq("sdo_in_latch", SDO, 0);
                done_cnt++;
                rises_frame = 0;
            end
`ifdef WS2801_UNDERRUN_EN
            if (underrun) urun_cnt++;
`endif
        end
        prev_cko = CKO;
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
    endtask

    task automatic wait_ready(input string tag);
        int unsigned k = 0;
        while (!pixel_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, pixel_ready, 1);
    endtask

    // Optionally lets the driver sit in LOAD for `gap` cycles before offering the pixel.
    task automatic feed_pixel(input logic [23:0] d, input int unsigned gap);
        if (gap != 0) begin
            wait_ready("load_wait");
            for (int unsigned i = 0; i < gap; i++) begin
                @(negedge clk);
                check_eq("cko_stall_low", CKO, 0);
            end
        end
        pixel_data  = d;
        pixel_valid = 1'b1;
        wait_ready("accept_wait");
        @(negedge clk);
        pixel_valid = 1'b0;
        pixel_data  = 24'($urandom);
    endtask

    task automatic wait_done();
        int unsigned k = 0;
        while (!frame_done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check_eq("frame_done_seen", frame_done, 1);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1, input int unsigned gap);
        int unsigned d0 = done_cnt;
        push_pixel(p0);
        push_pixel(p1);
        do_start();
        feed_pixel(p0, 0);
        feed_pixel(p1, gap);
        wait_done();
        check_eq("one_done_per_frame", done_cnt, d0 + 1);
    endtask

    initial begin
        logic [23:0]  p0, p1;
        int unsigned  d0;
        int unsigned  k;

        rst_n       = 1'b0;
        start       = 1'b0;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {CKO, SDO, busy, frame_done, pixel_ready}, 5'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_eq("idle_outputs", {CKO, SDO, busy, frame_done, pixel_ready}, 5'b0);
        end

        run_frame(24'hFFFFFF, 24'hF0F0F0, 0);

`ifdef WS2801_UNDERRUN_EN
        d0 = urun_cnt;
        push_pixel(24'hAAAAAA);
        push_pixel(24'h000000);
        do_start();
        feed_pixel(24'hAAAAAA, 0);
        wait_ready("underrun_load");
        repeat (31) @(negedge clk);
        pixel_data  = 24'h555555;
        pixel_valid = 1'b1;
        wait_done();
        check_eq("underrun_pulses", urun_cnt, d0 + 1);
        p1 = 24'($urandom);
        push_pixel(24'h555555);
        push_pixel(p1);
        do_start();
        feed_pixel(24'h555555, 0);
        feed_pixel(p1, 0);
        wait_done();
        check_eq("no_extra_underrun", urun_cnt, d0 + 1);
`else
        run_frame(24'hAAAAAA, 24'h555555, 30);
`endif

        // start pulsed mid-frame must be dropped, not queued
        d0 = done_cnt;
        p0 = 24'($urandom);
        p1 = 24'($urandom);
        push_pixel(p0);
        push_pixel(p1);
        do_start();
        feed_pixel(p0, 0);
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed_pixel(p1, 0);
        wait_done();
        repeat (20) @(negedge clk);
        check_eq("start_not_queued", busy, 0);
        check_eq("single_done_midstart", done_cnt, d0 + 1);

        for (int f = 0; f < 4; f++) begin
`ifdef WS2801_UNDERRUN_EN
            run_frame(24'($urandom), 24'($urandom), 0);
`else
            run_frame(24'($urandom), 24'($urandom), $urandom_range(0, 20));
`endif
        end

        // abort around bit 10 of the first pixel
        d0 = done_cnt;
        p0 = 24'($urandom);
        push_pixel(p0);
        do_start();
        feed_pixel(p0, 0);
        k = 0;
        while (rises_frame < 10 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_eq("reached_bit10", rises_frame >= 10, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_outputs", {CKO, SDO, busy, frame_done, pixel_ready}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (200) @(negedge clk);
        check_eq("abort_no_done", done_cnt, d0);
        check_eq("abort_idle", {CKO, busy}, 2'b0);
        run_frame(24'($urandom), 24'($urandom), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
